// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state type and default word width for the serializer
package piso_pkg;

    typedef enum logic {IDLE, SHIFT} piso_state_t;

    localparam int PISO_WIDTH = 4;

endpackage

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out stage with valid/ready input and sof/eof framing
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = PISO_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             x_o,
    output logic             x_vld_o,
    output logic             sof_o,
    output logic             eof_o,
    output logic             busy_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    piso_state_t      state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_bit;

    assign last_bit = (cnt_q == LAST);

    // ready depends only on registered state so valid_i never reaches it combinationally
    assign ready_o = (state_q == IDLE) || last_bit;

    assign busy_o  = (state_q == SHIFT);
    assign x_vld_o = busy_o;
    assign x_o     = busy_o & (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);
    assign sof_o   = busy_o && (cnt_q == '0);
    assign eof_o   = busy_o && last_bit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    sreg_d  = data_i;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!last_bit) begin
                    sreg_d = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                       : {1'b0, sreg_q[WIDTH-1:1]};
                    cnt_d  = cnt_q + CW'(1);
                end else if (valid_i) begin
                    // reload on the eof cycle so the next word follows with no gap
                    sreg_d = data_i;
                    cnt_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for MSB-first and LSB-first serializer instances
module tb_piso_serializer;
    import piso_pkg::*;

    localparam int W = PISO_WIDTH;

    typedef struct packed {
        logic         b;
        logic         s;
        logic         e;
        logic [W-1:0] w;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] data_i;
    logic         valid_i;

    logic m_ready, m_x, m_vld, m_sof, m_eof, m_busy;
    logic l_ready, l_x, l_vld, l_sof, l_eof, l_busy;

    exp_t exp_m[$];
    exp_t exp_l[$];

    int checks = 0;
    int errors = 0;

    logic [7:0]   log_m = '0;
    logic [7:0]   log_l = '0;
    int           vld_cnt = 0;
    logic [W-1:0] sr_model = '0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .data_i(data_i), .valid_i(valid_i),
        .ready_o(m_ready), .x_o(m_x), .x_vld_o(m_vld),
        .sof_o(m_sof), .eof_o(m_eof), .busy_o(m_busy)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .data_i(data_i), .valid_i(valid_i),
        .ready_o(l_ready), .x_o(l_x), .x_vld_o(l_vld),
        .sof_o(l_sof), .eof_o(l_eof), .busy_o(l_busy)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Hold valid until ready, handshake on the next edge, then push expected bits
    task automatic send(input logic [W-1:0] d);
        int n = 0;
        valid_i = 1'b1;
        data_i  = d;
        while (!m_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL hs_timeout: ready never rose, got 0 expected 1");
        end
        @(posedge clk);
        for (int i = 0; i < W; i++) begin
            exp_m.push_back('{b: d[W-1-i], s: (i == 0), e: (i == W-1), w: d});
            exp_l.push_back('{b: d[i],     s: (i == 0), e: (i == W-1), w: d});
        end
        #1;
        valid_i = 1'b0;
        data_i  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (exp_m.size() != 0) begin
                e = exp_m.pop_front();
                check1("m_vld", m_vld, 1'b1);
                check1("m_busy", m_busy, 1'b1);
                check1("m_x", m_x, e.b);
                check1("m_sof", m_sof, e.s);
                check1("m_eof", m_eof, e.e);
                check1("m_ready", m_ready, e.e);
                log_m    = {log_m[6:0], m_x};
                vld_cnt  = vld_cnt + 1;
                sr_model = {sr_model[W-2:0], m_x};
                if (e.e) check8("chain_sr", 8'(sr_model), 8'(e.w));
            end else begin
                check1("m_idle_vld", m_vld, 1'b0);
                check1("m_idle_x", m_x, 1'b0);
                check1("m_idle_ready", m_ready, 1'b1);
                check1("m_idle_busy", m_busy, 1'b0);
                check1("m_idle_sof", m_sof, 1'b0);
                check1("m_idle_eof", m_eof, 1'b0);
            end
            if (exp_l.size() != 0) begin
                e = exp_l.pop_front();
                check1("l_vld", l_vld, 1'b1);
                check1("l_x", l_x, e.b);
                check1("l_sof", l_sof, e.s);
                check1("l_eof", l_eof, e.e);
                check1("l_ready", l_ready, e.e);
                log_l = {log_l[6:0], l_x};
            end else begin
                check1("l_idle_vld", l_vld, 1'b0);
                check1("l_idle_x", l_x, 1'b0);
                check1("l_idle_ready", l_ready, 1'b1);
                check1("l_idle_busy", l_busy, 1'b0);
            end
        end
    end

    initial begin
        int c0;
        reset   = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        #1;
        check1("rst_ready", m_ready, 1'b1);
        check1("rst_x", m_x, 1'b0);
        check1("rst_vld", m_vld, 1'b0);
        check1("rst_sof", m_sof, 1'b0);
        check1("rst_eof", m_eof, 1'b0);
        check1("rst_busy", m_busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        idle(2);

        // single word, both bit orders
        log_m = '0; log_l = '0; vld_cnt = 0;
        send(4'b1011);
        idle(6);
        check8("single_msb_bits", log_m, 8'b0000_1011);
        check8("single_lsb_bits", log_l, 8'b0000_1101);
        check8("single_vld_cnt", 8'(vld_cnt), 8'd4);

        // back-to-back words
        log_m = '0; vld_cnt = 0;
        send(4'hA);
        send(4'h5);
        idle(6);
        check8("b2b_bits", log_m, 8'b1010_0101);
        check8("b2b_vld_cnt", 8'(vld_cnt), 8'd8);

        // stall: valid returns 3 cycles after eof
        vld_cnt = 0;
        send(4'h6);
        idle(3);
        check1("stall_eof", m_eof, 1'b1);
        idle(3);
        check1("stall_gap_idle", m_vld, 1'b0);
        send(4'h9);
        idle(5);
        check8("stall_vld_cnt", 8'(vld_cnt), 8'd8);

        // reset mid-word after two bits
        send(4'hF);
        @(posedge clk);
        #7;
        reset = 1'b0;
        exp_m.delete();
        exp_l.delete();
        #1;
        check1("midrst_vld", m_vld, 1'b0);
        check1("midrst_x", m_x, 1'b0);
        check1("midrst_busy", m_busy, 1'b0);
        check1("midrst_ready", m_ready, 1'b1);
        check1("midrst_l_vld", l_vld, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        c0 = vld_cnt;
        idle(6);
        check8("post_rst_no_bits", 8'(vld_cnt - c0), 8'd0);

        // chained with downstream shift register model
        for (int i = 0; i < 20; i++) begin
            send(W'($urandom));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
        end
        idle(8);
        check8("queue_m_empty", 8'(exp_m.size()), 8'd0);
        check8("queue_l_empty", 8'(exp_l.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
